rc4_stream_xor: RTL and testbench

Downstream consumer of the RC4 keystream generator `key_gene`. It buffers keystream bytes in a small FIFO and XORs them byte-for-byte with an incoming plaintext or ciphertext stream; RC4 is symmetric, so the same path encrypts and decrypts. It processes one message of programmable length per `start`, and emits a registered output stream with valid/ready handshakes on every port.

---
 rtl/rc4_stream_xor_if.sv | 23 ++
 rtl/rc4_stream_xor.sv | 79 +++++++
 tb/tb_rc4_stream_xor.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_stream_xor_if.sv
// rc4_stream_xor_if: control, keystream, input and output stream signals of rc4_stream_xor
interface rc4_stream_xor_if #(
    parameter int LEN_W = 16
);
    logic start;
    logic [LEN_W-1:0] msg_len;
    logic ks_valid, ks_ready;
    logic [7:0] ks_data;
    logic din_valid, din_ready;
    logic [7:0] din_data;
    logic dout_valid, dout_ready;
    logic [7:0] dout_data;
    logic busy, done;
    logic [LEN_W-1:0] byte_cnt;
    modport master (
        output start, msg_len, ks_valid, ks_data, din_valid, din_data, dout_ready,
        input ks_ready, din_ready, dout_valid, dout_data, busy, done, byte_cnt
    );
    modport slave (
        input start, msg_len, ks_valid, ks_data, din_valid, din_data, dout_ready,
        output ks_ready, din_ready, dout_valid, dout_data, busy, done, byte_cnt
    );
endinterface

// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: buffers RC4 keystream in a FIFO and XORs it onto a length-framed byte stream
module rc4_stream_xor #(
    parameter int KS_DEPTH = 4,
    parameter int LEN_W = 16
) (
    input logic clk,
    input logic rst,
    rc4_stream_xor_if.slave bus
);
    localparam int AW = $clog2(KS_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q, state_d;
    logic [7:0] mem_q [KS_DEPTH];
    logic [7:0] mem_d [KS_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, fill;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [7:0] dout_q, dout_d;
    logic dout_valid_q, dout_valid_d, done_q, done_d;
    logic full, empty, out_free, din_ok, push, pop;
    always_comb begin
        // pointers carry one extra bit so full and empty are distinguishable
        fill = wr_q - rd_q;
        full = fill == (AW+1)'(KS_DEPTH);
        empty = fill == '0;
        out_free = !dout_valid_q || bus.dout_ready;
        din_ok = state_q == RUN && cnt_q < len_q && !empty && out_free;
        push = bus.ks_valid && !full;
        pop = din_ok && bus.din_valid;
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = bus.ks_data;
        wr_d = wr_q + {{AW{1'b0}}, push};
        rd_d = rd_q + {{AW{1'b0}}, pop};
        dout_d = pop ? bus.din_data ^ mem_q[rd_q[AW-1:0]] : dout_q;
        dout_valid_d = pop || (dout_valid_q && !bus.dout_ready);
        state_d = state_q;
        done_d = 1'b0;
        len_d = len_q;
        cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, pop};
        if (state_q == IDLE && bus.start) begin
            state_d = RUN;
            len_d = bus.msg_len;
            cnt_d = '0;
        end
        if (state_q == RUN && cnt_q == len_q) state_d = FIN;
        if (state_q == FIN && out_free) begin
            state_d = IDLE;
            done_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q <= IDLE;
            wr_q <= '0;
            rd_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            dout_q <= '0;
            dout_valid_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            dout_q <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q <= done_d;
        end
    end
    assign bus.ks_ready = !full;
    assign bus.din_ready = din_ok;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_data = dout_q;
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.byte_cnt = cnt_q;
endmodule

// File: tb/tb_rc4_stream_xor.sv
// tb_rc4_stream_xor: directed and randomized checks of rc4_stream_xor against a queue-based model
module tb_rc4_stream_xor;
    localparam int KS_DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int n_done = 0;
    logic [7:0] ks_m[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] msg [16];
    rc4_stream_xor_if #(.LEN_W(16)) bus ();
    rc4_stream_xor #(.KS_DEPTH(KS_DEPTH), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic mid();
        if (clk) @(negedge clk);
    endtask
    // one clock: sample handshakes mid-cycle, advance the keystream/expected-output model at the edge
    task automatic tick(output bit acc);
        bit push;
        logic [7:0] d, k;
        mid();
        push = bus.ks_valid && ks_m.size() < KS_DEPTH;
        acc = bus.din_valid && bus.din_ready;
        d = bus.din_data;
        k = bus.ks_data;
        if (bus.dout_valid && bus.dout_ready) got_q.push_back(bus.dout_data);
        @(posedge clk);
        if (rst) begin
            ks_m.delete();
            exp_q.delete();
            got_q.delete();
        end else begin
            if (acc) begin
                if (ks_m.size() > 0) exp_q.push_back(d ^ ks_m.pop_front());
                else exp_q.push_back(~d);
            end
            if (push) ks_m.push_back(k);
        end
        #1;
        if (bus.done) n_done++;
    endtask
    task automatic clr();
        exp_q.delete();
        got_q.delete();
    endtask
    task automatic push_ks(input logic [7:0] k);
        bit acc;
        bus.ks_valid = 1'b1;
        bus.ks_data = k;
        tick(acc);
        bus.ks_valid = 1'b0;
    endtask
    task automatic start_msg(input int len);
        bit acc;
        bus.msg_len = 16'(len);
        bus.start = 1'b1;
        tick(acc);
        bus.start = 1'b0;
    endtask
    task automatic feed(input int n, input int first, input bit rnd, output int cyc);
        bit acc;
        int i;
        i = first;
        cyc = 0;
        while (!bus.done && cyc < 300) begin
            bus.din_valid = i < n && (!rnd || $urandom_range(0, 3) != 0);
            bus.din_data = i < n ? msg[i] : 8'($urandom);
            bus.dout_ready = !rnd || $urandom_range(0, 2) != 0;
            if (rnd) begin
                bus.ks_valid = 1'($urandom_range(0, 1));
                bus.ks_data = 8'($urandom);
            end
            tick(acc);
            if (acc) i++;
            cyc++;
        end
        bus.din_valid = 1'b0;
        bus.ks_valid = 1'b0;
        bus.dout_ready = 1'b1;
    endtask
    task automatic test_reset();
        bit acc;
        bus.start = 1'b0; bus.msg_len = '0; bus.ks_valid = 1'b0; bus.ks_data = '0;
        bus.din_valid = 1'b0; bus.din_data = '0; bus.dout_ready = 1'b1;
        rst = 1'b1;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        mid();
        total++;
        if ({bus.dout_valid, bus.dout_data, bus.busy, bus.done, bus.byte_cnt} !== 27'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {bus.dout_valid, bus.dout_data, bus.busy, bus.done, bus.byte_cnt});
        end
        total++;
        if ({bus.ks_ready, bus.din_ready} !== 2'b10) begin
            bad++;
            $display("FAIL reset_ready got=%b want=10", {bus.ks_ready, bus.din_ready});
        end
    endtask
    task automatic test_fifo_fill();
        bit acc;
        int cyc;
        bus.ks_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.ks_data = 8'(i + 1);
            mid();
            total++;
            if (bus.ks_ready !== (i < 4)) begin
                bad++;
                $display("FAIL fill_ks_ready[%0d] got=%b want=%b", i, bus.ks_ready, i < 4);
            end
            tick(acc);
        end
        bus.ks_valid = 1'b0;
        mid();
        total++;
        if ({bus.ks_ready, bus.din_ready} !== 2'b00) begin
            bad++;
            $display("FAIL fill_full got=%b want=00", {bus.ks_ready, bus.din_ready});
        end
        for (int k = 0; k < 4; k++) msg[k] = 8'h00;
        clr();
        start_msg(4);
        feed(4, 0, 1'b0, cyc);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_q[k] !== 8'(k + 1)) begin
                bad++;
                $display("FAIL fill_content[%0d] got=%h want=%h", k, got_q[k], 8'(k + 1));
            end
        end
    endtask
    task automatic test_back_to_back();
        int cyc, nd;
        logic [7:0] want [3];
        want = '{8'hBB, 8'h99, 8'hFF};
        push_ks(8'h11); push_ks(8'h22); push_ks(8'h33);
        msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
        clr();
        nd = n_done;
        start_msg(3);
        feed(3, 0, 1'b0, cyc);
        total++;
        if (cyc !== 5) begin
            bad++;
            $display("FAIL b2b_latency got=%0d want=5", cyc);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (got_q[k] !== want[k] || exp_q[k] !== want[k]) begin
                bad++;
                $display("FAIL b2b_data[%0d] got=%h model=%h want=%h", k, got_q[k], exp_q[k], want[k]);
            end
        end
        total++;
        if ({bus.byte_cnt, bus.busy, 32'(n_done - nd)} !== {16'd3, 1'b0, 32'd1}) begin
            bad++;
            $display("FAIL b2b_end cnt=%0d busy=%b dones=%0d want 3/0/1", bus.byte_cnt, bus.busy, n_done - nd);
        end
        begin
            bit acc;
            tick(acc);
        end
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_pulse got=%b want=0", bus.done);
        end
    endtask
    task automatic test_stall();
        bit acc;
        int cyc;
        logic [7:0] want [3];
        want = '{8'hBB, 8'h99, 8'hFF};
        push_ks(8'h11); push_ks(8'h22); push_ks(8'h33);
        msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
        clr();
        start_msg(3);
        bus.din_valid = 1'b1;
        bus.din_data = 8'hAA;
        bus.dout_ready = 1'b1;
        tick(acc);
        bus.dout_ready = 1'b0;
        bus.din_data = 8'hBB;
        for (int i = 0; i < 5; i++) begin
            mid();
            total++;
            if (bus.din_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_din_ready[%0d] got=%b want=0", i, bus.din_ready);
            end
            tick(acc);
            total++;
            if ({bus.dout_valid, bus.dout_data} !== {1'b1, 8'hBB}) begin
                bad++;
                $display("FAIL stall_hold[%0d] got=%b/%h want=1/bb", i, bus.dout_valid, bus.dout_data);
            end
        end
        feed(3, 1, 1'b0, cyc);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (got_q[k] !== want[k]) begin
                bad++;
                $display("FAIL stall_data[%0d] got=%h want=%h", k, got_q[k], want[k]);
            end
        end
    endtask
    task automatic test_empty_fifo();
        bit acc;
        int cyc;
        msg[0] = 8'h5A; msg[1] = 8'h81;
        clr();
        start_msg(2);
        bus.din_valid = 1'b1;
        bus.din_data = 8'h5A;
        bus.dout_ready = 1'b1;
        bus.ks_valid = 1'b1;
        bus.ks_data = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) bus.ks_valid = 1'b0;
            else bus.ks_valid = 1'b1;
            mid();
            total++;
            if (bus.din_ready !== 1'b0) begin
                bad++;
                $display("FAIL empty_din_ready[%0d] got=%b want=0", i, bus.din_ready);
            end
            tick(acc);
        end
        bus.ks_data = 8'hC3;
        mid();
        total++;
        if ({bus.din_ready, bus.dout_valid} !== 2'b10) begin
            bad++;
            $display("FAIL empty_after_push got=%b want=10", {bus.din_ready, bus.dout_valid});
        end
        tick(acc);
        bus.ks_valid = 1'b0;
        total++;
        if ({bus.dout_valid, bus.dout_data} !== {1'b1, 8'h66}) begin
            bad++;
            $display("FAIL empty_first_out got=%b/%h want=1/66", bus.dout_valid, bus.dout_data);
        end
        feed(2, 1, 1'b0, cyc);
        total++;
        if ({got_q[0], got_q[1], bus.byte_cnt} !== {8'h66, 8'h42, 16'd2}) begin
            bad++;
            $display("FAIL empty_data got=%h %h cnt=%0d want=66 42 cnt=2", got_q[0], got_q[1], bus.byte_cnt);
        end
    endtask
    task automatic test_zero_len();
        bit acc;
        int cyc, nd;
        push_ks(8'h77); push_ks(8'h88);
        nd = n_done;
        start_msg(0);
        total++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            bad++;
            $display("FAIL zero_e0 busy/done got=%b want=10", {bus.busy, bus.done});
        end
        bus.start = 1'b1;
        bus.msg_len = 16'd9;
        tick(acc);
        bus.start = 1'b0;
        total++;
        if ({bus.busy, bus.done, bus.dout_valid} !== 3'b100) begin
            bad++;
            $display("FAIL zero_e1 busy/done/dv got=%b want=100", {bus.busy, bus.done, bus.dout_valid});
        end
        tick(acc);
        total++;
        if ({bus.busy, bus.done, bus.dout_valid, bus.byte_cnt} !== {3'b010, 16'd0}) begin
            bad++;
            $display("FAIL zero_e2 busy/done/dv=%b cnt=%0d want=010 cnt=0", {bus.busy, bus.done, bus.dout_valid}, bus.byte_cnt);
        end
        tick(acc);
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++;
            $display("FAIL zero_ignored_start got=%b want=00", {bus.busy, bus.done});
        end
        msg[0] = 8'h00; msg[1] = 8'h00;
        clr();
        start_msg(2);
        feed(2, 0, 1'b0, cyc);
        total++;
        if ({got_q[0], got_q[1], 32'(n_done - nd)} !== {8'h77, 8'h88, 32'd2}) begin
            bad++;
            $display("FAIL zero_fifo_kept got=%h %h dones=%0d want=77 88 dones=2", got_q[0], got_q[1], n_done - nd);
        end
    endtask
    task automatic test_mid_reset();
        bit acc;
        int cyc, nd, n;
        logic [7:0] f [3];
        for (int k = 0; k < 5; k++) msg[k] = 8'($urandom);
        start_msg(5);
        n = 0;
        bus.din_valid = 1'b1;
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 40 && n < 2; c++) begin
            bus.ks_valid = 1'b1;
            bus.ks_data = 8'($urandom);
            bus.din_data = msg[n];
            tick(acc);
            if (acc) n++;
        end
        bus.din_valid = 1'b0;
        bus.ks_valid = 1'b0;
        nd = n_done;
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        mid();
        total++;
        if ({bus.dout_valid, bus.dout_data, bus.busy, bus.done, bus.byte_cnt, bus.ks_ready, bus.din_ready} !== {27'h0, 2'b10}) begin
            bad++;
            $display("FAIL midrst_state got=%h want=2", {bus.dout_valid, bus.dout_data, bus.busy, bus.done, bus.byte_cnt, bus.ks_ready, bus.din_ready});
        end
        for (int i = 0; i < 3; i++) tick(acc);
        for (int k = 0; k < 3; k++) begin
            f[k] = 8'($urandom);
            push_ks(f[k]);
            msg[k] = 8'($urandom);
        end
        clr();
        start_msg(3);
        feed(3, 0, 1'b0, cyc);
        total++;
        if (n_done - nd !== 1) begin
            bad++;
            $display("FAIL midrst_done_count got=%0d want=1", n_done - nd);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (got_q[k] !== (msg[k] ^ f[k])) begin
                bad++;
                $display("FAIL midrst_data[%0d] got=%h want=%h", k, got_q[k], msg[k] ^ f[k]);
            end
        end
    endtask
    task automatic test_random();
        int cyc, nd, len;
        bit ok;
        for (int m = 0; m < 25; m++) begin
            len = $urandom_range(0, 12);
            for (int k = 0; k < 16; k++) msg[k] = 8'($urandom);
            clr();
            nd = n_done;
            start_msg(len);
            feed(len, 0, 1'b1, cyc);
            ok = got_q.size() == len && exp_q.size() == len;
            for (int k = 0; k < len; k++) ok = ok && got_q[k] === exp_q[k];
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rand_stream[%0d] got_n=%0d model_n=%0d want_n=%0d", m, got_q.size(), exp_q.size(), len);
            end
            total++;
            if ({bus.byte_cnt, 32'(n_done - nd)} !== {16'(len), 32'd1}) begin
                bad++;
                $display("FAIL rand_end[%0d] cnt=%0d dones=%0d want cnt=%0d dones=1", m, bus.byte_cnt, n_done - nd, len);
            end
        end
    endtask
    initial begin
        test_reset();
        test_fifo_fill();
        test_back_to_back();
        test_stall();
        test_empty_fifo();
        test_zero_len();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
